regfile_wb_arbiter: RTL

//  Shares the register file's single write port between two writeback sources:

---
 rtl/regfile_wb_arbiter_if.sv | 39 +++
 rtl/regfile_wb_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two result sources, the register-file write port and the hazard lookup.
// The master drives requests and lookups; the slave (the arbiter) answers and drives the regfile write.
interface regfile_wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              a_valid;
    logic              a_ready;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              b_valid;
    logic              b_ready;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              reg_write;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic [ADDR_W-1:0] pend_addr;
    logic              pend_hit;
    logic              idle;

    modport master (
        output a_valid, a_addr, a_data,
        output b_valid, b_addr, b_data,
        output pend_addr,
        input  a_ready, b_ready,
        input  reg_write, write_reg, write_data,
        input  pend_hit, idle
    );

    modport slave (
        input  a_valid, a_addr, a_data,
        input  b_valid, b_addr, b_data,
        input  pend_addr,
        output a_ready, b_ready,
        output reg_write, write_reg, write_data,
        output pend_hit, idle
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between two FIFO-buffered sources.
// Define WB_ARB_STATS_EN to add the saturating conflict_cnt output.
module regfile_wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset,
    regfile_wb_arbiter_if.slave bus
`ifdef WB_ARB_STATS_EN
    ,
    output logic [15:0]        conflict_cnt
`endif
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [0:0] RR_A = 1'b0;
    localparam logic [0:0] RR_B = 1'b1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    // Index 0 is source A, index 1 is source B.
    entry_t           mem     [2][FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr  [2];
    logic [PTR_W-1:0] rd_ptr  [2];
    logic [CNT_W-1:0] count   [2];

    logic             src_valid [2];
    entry_t           src_ent   [2];
    logic             full      [2];
    logic             not_empty [2];
    logic             ready     [2];
    logic             push      [2];
    logic             pop       [2];
    entry_t           head      [2];

    logic [0:0]        rr_last;
    logic              grant_a;
    logic              grant_b;
    logic              reg_write_q;
    logic [ADDR_W-1:0] write_reg_q;
    logic [DATA_W-1:0] write_data_q;
    logic              pend_hit_c;

    always_comb begin
        src_valid[0]      = bus.a_valid;
        src_valid[1]      = bus.b_valid;
        src_ent[0].addr   = bus.a_addr;
        src_ent[0].data   = bus.a_data;
        src_ent[1].addr   = bus.b_addr;
        src_ent[1].data   = bus.b_data;
    end

    // Ready never depends on a same-cycle pop, so a full FIFO always refuses.
    always_comb begin
        for (int unsigned s = 0; s < 2; s++) begin
            full[s]      = (count[s] == CNT_W'(FIFO_DEPTH));
            not_empty[s] = (count[s] != '0);
            ready[s]     = !reset && !full[s];
            push[s]      = src_valid[s] && ready[s] && (src_ent[s].addr != '0);
            head[s]      = mem[s][rd_ptr[s]];
        end
    end

    always_comb begin
        grant_a = not_empty[0] && (!not_empty[1] || (rr_last == RR_B));
        grant_b = not_empty[1] && (!not_empty[0] || (rr_last == RR_A));
        pop[0]  = grant_a;
        pop[1]  = grant_b;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned s = 0; s < 2; s++) begin
                wr_ptr[s] <= '0;
                rd_ptr[s] <= '0;
                count[s]  <= '0;
            end
        end else begin
            for (int unsigned s = 0; s < 2; s++) begin
                if (push[s]) begin
                    mem[s][wr_ptr[s]] <= src_ent[s];
                    wr_ptr[s]         <= wr_ptr[s] + 1'b1;
                end
                if (pop[s]) begin
                    rd_ptr[s] <= rd_ptr[s] + 1'b1;
                end
                case ({push[s], pop[s]})
                    2'b10:   count[s] <= count[s] + 1'b1;
                    2'b01:   count[s] <= count[s] - 1'b1;
                    default: count[s] <= count[s];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_last      <= RR_B;
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else if (grant_a) begin
            rr_last      <= RR_A;
            reg_write_q  <= 1'b1;
            write_reg_q  <= head[0].addr;
            write_data_q <= head[0].data;
        end else if (grant_b) begin
            rr_last      <= RR_B;
            reg_write_q  <= 1'b1;
            write_reg_q  <= head[1].addr;
            write_data_q <= head[1].data;
        end else begin
            reg_write_q  <= 1'b0;
        end
    end

    // Occupied slots are the count entries starting at the read pointer, modulo depth.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx        = '0;
        pend_hit_c = reg_write_q && (write_reg_q == bus.pend_addr);
        for (int unsigned s = 0; s < 2; s++) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                idx = rd_ptr[s] + PTR_W'(i);
                if ((CNT_W'(i) < count[s]) && (mem[s][idx].addr == bus.pend_addr)) begin
                    pend_hit_c = 1'b1;
                end
            end
        end
        if (bus.pend_addr == '0) begin
            pend_hit_c = 1'b0;
        end
    end

`ifdef WB_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_cnt <= '0;
        end else if (not_empty[0] && not_empty[1] && (conflict_cnt != '1)) begin
            conflict_cnt <= conflict_cnt + 1'b1;
        end
    end
`endif

    assign bus.a_ready    = ready[0];
    assign bus.b_ready    = ready[1];
    assign bus.reg_write  = reg_write_q;
    assign bus.write_reg  = write_reg_q;
    assign bus.write_data = write_data_q;
    assign bus.pend_hit   = pend_hit_c;
    assign bus.idle       = !not_empty[0] && !not_empty[1] && !reg_write_q;

endmodule
